// File: rtl/ysyx_23060025_ifu_fq_stage_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_ifu_fq_stage_pkg
// Shared definitions for the queued fetch stage:
//   PC_RESET_VAL  - address of the first fetch after reset
//   FS_TO_DS_W    - width of the {inst, pc} bus handed to IDU
//   redir_src_e   - which source (if any) is redirecting fetch this cycle
//   redir_select  - resolves simultaneous redirect requests by priority
// ---------------------------------------------------------------------------
package ysyx_23060025_ifu_fq_stage_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FS_TO_DS_W = DATA_W + ADDR_W;

    localparam logic [31:0] PC_RESET_VAL = 32'h3000_0000;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_FLUSH,
        REDIR_CSR,
        REDIR_JMP
    } redir_src_e;

    // A pipeline flush comes from the oldest instruction, so it overrides a
    // CSR trap/return, which in turn overrides an ordinary resolved jump.
    function automatic redir_src_e redir_select(input logic flush_req,
                                                input logic csr_req,
                                                input logic jmp_req);
        redir_src_e src;
        src = REDIR_NONE;
        if (flush_req) begin
            src = REDIR_FLUSH;
        end else if (csr_req) begin
            src = REDIR_CSR;
        end else if (jmp_req) begin
            src = REDIR_JMP;
        end
        return src;
    endfunction

endpackage

// File: rtl/ysyx_23060025_sync_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_sync_fifo
// Single-clock FIFO with a synchronous flush.
//   clock, reset     - clock and asynchronous active-high reset
//   push, push_data  - write request and data
//   pop, pop_data    - read request; pop_data always shows the head entry
//   flush            - empties the FIFO, overriding push and pop
//   full, empty      - occupancy flags
//   count            - number of stored entries (0..DEPTH)
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
// ---------------------------------------------------------------------------
module ysyx_23060025_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two pointer ranges stay legal.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Effective handshakes: flush wins, and the pop frees the slot a push
    // into a full FIFO needs.
    always_comb begin
        do_pop  = pop & ~empty & ~flush;
        do_push = push & ~flush & (~full | do_pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty masks stale contents.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ysyx_23060025_ifu_fq_stage.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_ifu_fq_stage
// Fetch stage that keeps up to MAX_OUTSTANDING icache requests in flight and
// buffers returned instructions in a FQ_DEPTH-entry queue in front of IDU.
//   clock, reset               - clock and asynchronous active-high reset
//   idu_valid_i                - qualifies idu_flush_i and jmp_flag_i
//   idu_flush_i/idu_flush_pc_i - pipeline flush and its target
//   csr_jmp_i/csr_pc_i         - CSR redirect and its target
//   jmp_flag_i/jmp_target_i    - resolved jump and its target
//   bpu_pc_o/bpu_pc_predict_i  - current fetch PC and its predicted successor
//   req_valid_o/req_ready_i/req_addr_o - icache request channel
//   resp_valid_i/resp_data_i   - in-order icache responses (never stalled)
//   fs_to_ds_valid_o/ds_allowin_i/if_to_id_bus_o - {inst, pc} to IDU
// On a redirect the queues are emptied at once and responses for requests
// already in flight are counted off by drop_cnt instead of waited for.
// ---------------------------------------------------------------------------
module ysyx_23060025_ifu_fq_stage #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int FQ_DEPTH        = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET_VAL =
        ADDR_WIDTH'(ysyx_23060025_ifu_fq_stage_pkg::PC_RESET_VAL)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             idu_valid_i,
    input  logic                             idu_flush_i,
    input  logic [ADDR_WIDTH-1:0]            idu_flush_pc_i,
    input  logic                             csr_jmp_i,
    input  logic [ADDR_WIDTH-1:0]            csr_pc_i,
    input  logic                             jmp_flag_i,
    input  logic [ADDR_WIDTH-1:0]            jmp_target_i,
    output logic [ADDR_WIDTH-1:0]            bpu_pc_o,
    input  logic [ADDR_WIDTH-1:0]            bpu_pc_predict_i,
    output logic                             req_valid_o,
    input  logic                             req_ready_i,
    output logic [ADDR_WIDTH-1:0]            req_addr_o,
    input  logic                             resp_valid_i,
    input  logic [DATA_WIDTH-1:0]            resp_data_i,
    output logic                             fs_to_ds_valid_o,
    input  logic                             ds_allowin_i,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] if_to_id_bus_o
);

    import ysyx_23060025_ifu_fq_stage_pkg::*;

    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FQ_CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam int SUM_W    = ((CNT_W > FQ_CNT_W) ? CNT_W : FQ_CNT_W) + 1;
    localparam int BUS_W    = DATA_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      drop_cnt;

    redir_src_e            redir_src;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;

    logic [SUM_W-1:0]      credit_used;
    logic                  has_credit;
    logic                  issue;
    logic                  resp_live;
    logic                  resp_drop;

    logic [ADDR_WIDTH-1:0] pc_head;
    logic                  pc_full;
    logic                  pc_empty;
    logic [CNT_W-1:0]      pc_count;

    logic                  fq_push;
    logic                  fq_pop;
    logic [BUS_W-1:0]      fq_head;
    logic                  fq_full;
    logic                  fq_empty;
    logic [FQ_CNT_W-1:0]   fq_count;

    // Pick the redirect source and its target.
    always_comb begin
        redir_src = redir_select(idu_flush_i & idu_valid_i,
                                 csr_jmp_i,
                                 jmp_flag_i & idu_valid_i);
        redirect  = (redir_src != REDIR_NONE);
        case (redir_src)
            REDIR_FLUSH: redirect_target = idu_flush_pc_i;
            REDIR_CSR:   redirect_target = csr_pc_i;
            REDIR_JMP:   redirect_target = jmp_target_i;
            default:     redirect_target = fetch_pc;
        endcase
    end

    // Only issue when every in-flight response is guaranteed a queue slot,
    // which is why responses never need back-pressure. In-flight requests
    // that will be dropped still hold credit until they return.
    always_comb begin
        credit_used = SUM_W'(outstanding) + SUM_W'(fq_count);
        has_credit  = (outstanding < CNT_W'(MAX_OUTSTANDING)) &&
                      (credit_used < SUM_W'(FQ_DEPTH));
        req_valid_o = ~reset & ~redirect & has_credit;
        issue       = req_valid_o & req_ready_i;
        resp_live   = resp_valid_i & ~redirect & (drop_cnt == '0);
        resp_drop   = resp_valid_i & ~redirect & (drop_cnt != '0);
        fq_push     = resp_live;
        fq_pop      = fs_to_ds_valid_o & ds_allowin_i;
    end

    assign bpu_pc_o         = fetch_pc;
    assign req_addr_o       = fetch_pc;
    assign fs_to_ds_valid_o = ~fq_empty & ~redirect;
    assign if_to_id_bus_o   = fq_empty ? '0 : fq_head;

    // Fetch PC, in-flight count and the number of stale responses to skip.
    // A response landing in the redirect cycle is already stale, so it is
    // removed from both counts instead of being scheduled for dropping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= PC_RESET_VAL;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_target;
            outstanding <= outstanding - CNT_W'(resp_valid_i);
            drop_cnt    <= outstanding - CNT_W'(resp_valid_i);
        end else begin
            if (issue) begin
                fetch_pc <= bpu_pc_predict_i;
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp_valid_i);
            if (resp_drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    // Addresses of live in-flight requests, matched to responses in order.
    ysyx_23060025_sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .pop_data  (pc_head),
        .flush     (redirect),
        .full      (pc_full),
        .empty     (pc_empty),
        .count     (pc_count)
    );

    // Fetched {inst, pc} pairs waiting for IDU.
    ysyx_23060025_sync_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clock     (clock),
        .reset     (reset),
        .push      (fq_push),
        .push_data ({resp_data_i, pc_head}),
        .pop       (fq_pop),
        .pop_data  (fq_head),
        .flush     (redirect),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    // Protocol and bookkeeping invariants.
    a_no_resp_when_idle: assert property (@(posedge clock) disable iff (reset)
        resp_valid_i |-> (outstanding != '0));
    a_fq_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(fq_push && fq_full && !fq_pop));
    a_drop_bounded: assert property (@(posedge clock) disable iff (reset)
        drop_cnt <= outstanding);
    a_pc_fifo_tracks: assert property (@(posedge clock) disable iff (reset)
        pc_count == (outstanding - drop_cnt));
    a_pc_fifo_has_entry: assert property (@(posedge clock) disable iff (reset)
        resp_live |-> !pc_empty);
    a_pc_fifo_has_room: assert property (@(posedge clock) disable iff (reset)
        issue |-> !pc_full);

endmodule

// File: tb/tb_ysyx_23060025_ifu_fq_stage.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060025_ifu_fq_stage
// Directed bench for the queued fetch stage. A small icache stub answers each
// request after resp_lat cycles with data = addr ^ 0xFF; the BPU stub always
// predicts pc + 4. Expected IDU beats are queued by the stimulus and consumed
// by an independent monitor.
// ---------------------------------------------------------------------------
module tb_ysyx_23060025_ifu_fq_stage;

    import ysyx_23060025_ifu_fq_stage_pkg::*;

    logic                  clock;
    logic                  reset;
    logic                  idu_valid_i;
    logic                  idu_flush_i;
    logic [31:0]           idu_flush_pc_i;
    logic                  csr_jmp_i;
    logic [31:0]           csr_pc_i;
    logic                  jmp_flag_i;
    logic [31:0]           jmp_target_i;
    logic [31:0]           bpu_pc_o;
    logic [31:0]           bpu_pc_predict_i;
    logic                  req_valid_o;
    logic                  req_ready_i;
    logic [31:0]           req_addr_o;
    logic                  resp_valid_i;
    logic [31:0]           resp_data_i;
    logic                  fs_to_ds_valid_o;
    logic                  ds_allowin_i;
    logic [FS_TO_DS_W-1:0] if_to_id_bus_o;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    logic [63:0] exp_q[$];
    int          pop_cyc[$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int first_issue_cyc = 0;
    int last_issue_cyc = 0;
    int resp_lat = 1;

    ysyx_23060025_ifu_fq_stage dut (
        .clock            (clock),
        .reset            (reset),
        .idu_valid_i      (idu_valid_i),
        .idu_flush_i      (idu_flush_i),
        .idu_flush_pc_i   (idu_flush_pc_i),
        .csr_jmp_i        (csr_jmp_i),
        .csr_pc_i         (csr_pc_i),
        .jmp_flag_i       (jmp_flag_i),
        .jmp_target_i     (jmp_target_i),
        .bpu_pc_o         (bpu_pc_o),
        .bpu_pc_predict_i (bpu_pc_predict_i),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .req_addr_o       (req_addr_o),
        .resp_valid_i     (resp_valid_i),
        .resp_data_i      (resp_data_i),
        .fs_to_ds_valid_o (fs_to_ds_valid_o),
        .ds_allowin_i     (ds_allowin_i),
        .if_to_id_bus_o   (if_to_id_bus_o)
    );

    assign bpu_pc_predict_i = bpu_pc_o + 32'd4;

    // Free-running clock and cycle index.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        cyc++;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Record accepted requests and schedule their icache responses.
    always @(negedge clock) begin
        if (!reset && req_valid_o && req_ready_i) begin
            issue_cnt++;
            if (issue_cnt == 1) begin
                first_issue_cyc = cyc;
            end
            last_issue_cyc = cyc;
            pending.push_back('{addr: req_addr_o, due: cyc + resp_lat});
        end
    end

    // Icache stub: one in-order response per cycle; forgets everything on reset.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            pending.delete();
            resp_valid_i = 1'b0;
            resp_data_i  = '0;
        end else if (pending.size() > 0 && pending[0].due <= cyc) begin
            resp_valid_i = 1'b1;
            resp_data_i  = pending[0].addr ^ 32'h0000_00FF;
            void'(pending.pop_front());
        end else begin
            resp_valid_i = 1'b0;
        end
    end

    // Scoreboard monitor: every beat IDU takes must be the next expected one.
    always @(negedge clock) begin
        if (!reset && fs_to_ds_valid_o && ds_allowin_i) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("[TB] FAIL idu_unexpected: got %h, expected no beat", if_to_id_bus_o);
            end else begin
                check_output("idu_bus", if_to_id_bus_o, exp_q.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic apply_stimulus(input logic [63:0] beat);
        exp_q.push_back(beat);
    endtask

    task automatic wait_issues(input int n, input int budget);
        int k = 0;
        while (issue_cnt < n && k < budget) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (issue_cnt < n) begin
            check_output("issue_timeout", 64'(issue_cnt), 64'(n));
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (exp_q.size() > 0) begin
            check_output("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        idu_valid_i    = 1'b0;
        idu_flush_i    = 1'b0;
        idu_flush_pc_i = '0;
        csr_jmp_i      = 1'b0;
        csr_pc_i       = '0;
        jmp_flag_i     = 1'b0;
        jmp_target_i   = '0;
        req_ready_i    = 1'b0;
        ds_allowin_i   = 1'b0;
        resp_valid_i   = 1'b0;
        resp_data_i    = '0;

        // Reset state.
        repeat (3) step();
        req_ready_i = 1'b1;
        #1;
        check_output("rst_req_valid", 64'(req_valid_o), 64'd0);
        check_output("rst_fs_valid", 64'(fs_to_ds_valid_o), 64'd0);
        check_output("rst_bus", if_to_id_bus_o, 64'd0);
        check_output("rst_pc", 64'(bpu_pc_o), 64'h3000_0000);

        // Streaming fetch, one beat per cycle once filled.
        step();
        issue_cnt = 0;
        pop_cyc.delete();
        resp_lat = 1;
        ds_allowin_i = 1'b1;
        apply_stimulus({32'h3000_00FF, 32'h3000_0000});
        apply_stimulus({32'h3000_00FB, 32'h3000_0004});
        apply_stimulus({32'h3000_00F7, 32'h3000_0008});
        reset = 1'b0;
        wait_issues(3, 20);
        req_ready_i = 1'b0;
        drain(30);
        if (pop_cyc.size() == 3) begin
            check_output("stream_latency", 64'(pop_cyc[0] - first_issue_cyc), 64'd2);
            check_output("stream_spacing", 64'(pop_cyc[2] - pop_cyc[0]), 64'd2);
        end else begin
            check_output("stream_beats", 64'(pop_cyc.size()), 64'd3);
        end

        // IDU stalled: the queue fills and issue stops at FQ_DEPTH.
        issue_cnt = 0;
        ds_allowin_i = 1'b0;
        req_ready_i = 1'b1;
        apply_stimulus({32'h3000_00F3, 32'h3000_000C});
        apply_stimulus({32'h3000_00EF, 32'h3000_0010});
        apply_stimulus({32'h3000_00EB, 32'h3000_0014});
        apply_stimulus({32'h3000_00E7, 32'h3000_0018});
        repeat (10) step();
        @(negedge clock);
        check_output("stall_issues", 64'(issue_cnt), 64'd4);
        check_output("stall_req_valid", 64'(req_valid_o), 64'd0);
        check_output("stall_fq_count", 64'(dut.fq_count), 64'd4);
        check_output("stall_fs_valid", 64'(fs_to_ds_valid_o), 64'd1);
        step();
        req_ready_i = 1'b0;
        ds_allowin_i = 1'b1;
        drain(30);

        // Jump with two requests in flight: both stale responses are dropped.
        issue_cnt = 0;
        resp_lat = 5;
        req_ready_i = 1'b1;
        wait_issues(2, 20);
        req_ready_i = 1'b0;
        idu_valid_i = 1'b1;
        jmp_flag_i = 1'b1;
        jmp_target_i = 32'h3000_0100;
        apply_stimulus({32'h3000_01FF, 32'h3000_0100});
        step();
        idu_valid_i = 1'b0;
        jmp_flag_i = 1'b0;
        req_ready_i = 1'b1;
        @(negedge clock);
        check_output("jmp_drop_cnt", 64'(dut.drop_cnt), 64'd2);
        check_output("jmp_outstanding", 64'(dut.outstanding), 64'd2);
        check_output("jmp_pc", 64'(bpu_pc_o), 64'h3000_0100);
        wait_issues(3, 30);
        req_ready_i = 1'b0;
        drain(40);
        check_output("jmp_drop_done", 64'(dut.drop_cnt), 64'd0);

        // Flush and CSR redirect together: the flush target wins.
        issue_cnt = 0;
        resp_lat = 1;
        idu_valid_i = 1'b1;
        idu_flush_i = 1'b1;
        idu_flush_pc_i = 32'h0000_0080;
        csr_jmp_i = 1'b1;
        csr_pc_i = 32'h0000_0200;
        @(negedge clock);
        check_output("redir_no_issue", 64'(req_valid_o), 64'd0);
        step();
        idu_valid_i = 1'b0;
        idu_flush_i = 1'b0;
        csr_jmp_i = 1'b0;
        @(negedge clock);
        check_output("prio_pc", 64'(bpu_pc_o), 64'h0000_0080);
        apply_stimulus({32'h0000_007F, 32'h0000_0080});
        step();
        req_ready_i = 1'b1;
        wait_issues(1, 20);
        req_ready_i = 1'b0;
        drain(30);

        // Response arriving in the redirect cycle is discarded, nothing dropped later.
        issue_cnt = 0;
        resp_lat = 3;
        req_ready_i = 1'b1;
        wait_issues(1, 20);
        req_ready_i = 1'b0;
        while (cyc < last_issue_cyc + 3) begin
            step();
        end
        csr_jmp_i = 1'b1;
        csr_pc_i = 32'h0000_0400;
        @(negedge clock);
        check_output("coinc_resp_seen", 64'(resp_valid_i), 64'd1);
        check_output("coinc_fs_valid", 64'(fs_to_ds_valid_o), 64'd0);
        step();
        csr_jmp_i = 1'b0;
        @(negedge clock);
        check_output("coinc_drop_cnt", 64'(dut.drop_cnt), 64'd0);
        check_output("coinc_outstanding", 64'(dut.outstanding), 64'd0);
        check_output("coinc_fq_empty", 64'(fs_to_ds_valid_o), 64'd0);
        check_output("coinc_pc", 64'(bpu_pc_o), 64'h0000_0400);

        // Asynchronous reset with two requests in flight.
        issue_cnt = 0;
        resp_lat = 4;
        step();
        req_ready_i = 1'b1;
        wait_issues(2, 20);
        #2;
        reset = 1'b1;
        #1;
        check_output("arst_req_valid", 64'(req_valid_o), 64'd0);
        check_output("arst_fs_valid", 64'(fs_to_ds_valid_o), 64'd0);
        check_output("arst_bus", if_to_id_bus_o, 64'd0);
        check_output("arst_pc", 64'(bpu_pc_o), 64'h3000_0000);
        check_output("arst_outstanding", 64'(dut.outstanding), 64'd0);
        repeat (2) step();
        issue_cnt = 0;
        resp_lat = 1;
        apply_stimulus({32'h3000_00FF, 32'h3000_0000});
        apply_stimulus({32'h3000_00FB, 32'h3000_0004});
        reset = 1'b0;
        wait_issues(2, 20);
        req_ready_i = 1'b0;
        drain(30);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
